// File: rtl/palette_arbiter.sv
// Arbitrates the single-port 32x8 palette RAM between renderer lookups and buffered CPU accesses.
// Optional feature: define PALETTE_GRAYSCALE_EN to mask render colour bytes with PPUMASK grayscale.
module palette_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       render_req,
  input  logic [4:0] render_addr,
  output logic [7:0] render_data,
  output logic       render_valid,
  input  logic       grayscale,
  input  logic       cpu_wr_req,
  input  logic       cpu_rd_req,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_wr_ack,
  output logic       cpu_rd_ack,
  output logic [7:0] cpu_rdata,
  output logic       fifo_full,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {GRANT_RENDER, GRANT_WR, GRANT_RD, IDLE} grant_e;
  grant_e state, state_next;

  logic [4:0]    fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [SW-1:0] starve_cnt;
  logic          rd_blocked;
  logic          fifo_empty, rd_pending, cpu_pending, forced, rd_ok, pop, push;
  logic [7:0]    render_byte;

  function automatic logic [4:0] mirror(input logic [4:0] a);
    return (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rd_pending  = cpu_rd_req & ~rd_blocked;
  assign cpu_pending = ~fifo_empty | rd_pending;
  assign forced      = cpu_pending && (starve_cnt == SW'(STARVE_MAX));
  // A write arriving this cycle must land before any read so the read sees it.
  assign rd_ok       = rd_pending & fifo_empty & ~cpu_wr_req;
  assign pop         = (state_next == GRANT_WR);
  assign cpu_wr_ack  = cpu_wr_req & (~fifo_full | pop);
  assign push        = cpu_wr_ack;
  assign cpu_rd_ack  = (state == GRANT_RD);

`ifdef PALETTE_GRAYSCALE_EN
  assign render_byte = grayscale ? (mem_rdata & 8'h30) : mem_rdata;
`else
  logic unused_grayscale;
  assign unused_grayscale = grayscale;
  assign render_byte = mem_rdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= GRANT_RENDER;
    else          state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    if (forced && !fifo_empty)  state_next = GRANT_WR;
    else if (forced && rd_ok)   state_next = GRANT_RD;
    else if (render_req)        state_next = GRANT_RENDER;
    else if (!fifo_empty)       state_next = GRANT_WR;
    else if (rd_ok)             state_next = GRANT_RD;
    case (state_next)
      GRANT_RENDER: mem_addr = mirror(render_addr);
      GRANT_WR: begin
        mem_addr  = fifo_addr[rd_ptr[PW-1:0]];
        mem_wdata = fifo_data[rd_ptr[PW-1:0]];
        mem_we    = 1'b1;
      end
      GRANT_RD: mem_addr = mirror(cpu_addr);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= mirror(cpu_addr);
      fifo_data[wr_ptr[PW-1:0]] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      starve_cnt   <= '0;
      rd_blocked   <= 1'b0;
      render_valid <= 1'b0;
      render_data  <= '0;
      cpu_rdata    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      if (state_next == GRANT_WR || state_next == GRANT_RD || !cpu_pending)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
      // One read per request: re-arm only once the CPU drops cpu_rd_req.
      if (state_next == GRANT_RD) rd_blocked <= 1'b1;
      else if (!cpu_rd_req)       rd_blocked <= 1'b0;
      render_valid <= (state_next == GRANT_RENDER);
      if (state_next == GRANT_RENDER) render_data <= render_byte;
      if (state_next == GRANT_RD)     cpu_rdata   <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: vector table, corner sequences, random run vs queue model.
module tb_palette_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SMAX  = 8;

  logic       clk = 0, reset_n = 0;
  logic       render_req = 0, grayscale = 0, cpu_wr_req = 0, cpu_rd_req = 0;
  logic [4:0] render_addr = '0, cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] render_data, cpu_rdata, mem_wdata, mem_rdata;
  logic       render_valid, cpu_wr_ack, cpu_rd_ack, fifo_full, mem_we;
  logic [4:0] mem_addr;

  palette_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n), .render_req(render_req), .render_addr(render_addr),
    .render_data(render_data), .render_valid(render_valid), .grayscale(grayscale),
    .cpu_wr_req(cpu_wr_req), .cpu_rd_req(cpu_rd_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wr_ack(cpu_wr_ack), .cpu_rd_ack(cpu_rd_ack),
    .cpu_rdata(cpu_rdata), .fifo_full(fifo_full), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Palette RAM stand-in: async read, negedge write.
  logic [7:0] pal [32];
  assign mem_rdata = pal[mem_addr];
  always @(negedge clk) if (mem_we) pal[mem_addr] <= mem_wdata;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    if (i == 1) return 8'h29;
    if (i == 2) return 8'h1A;
    if (i == 4) return 8'h22;
    return 8'((i * 7 + 3) % 64);
  endfunction

  function automatic logic [4:0] mirror(input int a);
    return (a >= 16 && a % 4 == 0) ? 5'(a - 16) : 5'(a);
  endfunction

  function automatic logic [7:0] shade(input logic [7:0] d, input logic g);
`ifdef PALETTE_GRAYSCALE_EN
    return g ? (d & 8'h30) : d;
`else
    return d;
`endif
  endfunction

  // Reference model: queue of pending writes, shadow palette, starvation count.
  typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;
  wr_t        m_q[$];
  logic [7:0] m_mem [32];
  int         m_starve;
  bit         m_blk;
  logic       m_rv, m_ack;
  logic [7:0] m_rdat, m_crd;
  logic       e_we, e_ack, e_full;
  logic [4:0] e_addr;
  logic [7:0] e_wdata;

  task automatic model_reset();
    m_q.delete();
    m_starve = 0; m_blk = 0; m_rv = 0; m_ack = 0; m_rdat = 0; m_crd = 0;
  endtask

  // Evaluate the current cycle against the model, check combinational outputs, advance model.
  task automatic settle();
    int n, g;
    bit rd_pend, pend, forced, rd_ok;
    #1;
    n       = m_q.size();
    rd_pend = cpu_rd_req && !m_blk;
    pend    = (n > 0) || rd_pend;
    forced  = pend && (m_starve == SMAX);
    rd_ok   = rd_pend && n == 0 && !cpu_wr_req;
    if (forced && n > 0)  g = 2;
    else if (forced && rd_ok) g = 3;
    else if (render_req)  g = 1;
    else if (n > 0)       g = 2;
    else if (rd_ok)       g = 3;
    else                  g = 0;
    e_we    = (g == 2);
    e_addr  = (g == 1) ? mirror(int'(render_addr)) : (g == 2) ? m_q[0].a :
              (g == 3) ? mirror(int'(cpu_addr)) : 5'd0;
    e_wdata = (g == 2) ? m_q[0].d : 8'd0;
    e_full  = (n == DEPTH);
    e_ack   = cpu_wr_req && (n < DEPTH || g == 2);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_wr_ack", cpu_wr_ack, e_ack);
    chk("fifo_full", fifo_full, e_full);
    m_rv  = (g == 1);
    m_ack = (g == 3);
    if (g == 1) m_rdat = shade(m_mem[mirror(int'(render_addr))], grayscale);
    if (g == 3) m_crd  = m_mem[mirror(int'(cpu_addr))];
    if (g == 2) begin
      m_mem[m_q[0].a] = m_q[0].d;
      m_q.delete(0);
    end
    if (e_ack) m_q.push_back('{a: mirror(int'(cpu_addr)), d: cpu_wdata});
    if (g == 2 || g == 3 || !pend) m_starve = 0;
    else if (m_starve < SMAX)      m_starve++;
    if (g == 3)           m_blk = 1;
    else if (!cpu_rd_req) m_blk = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    chk("render_valid", render_valid, m_rv);
    chk("render_data", render_data, m_rdat);
    chk("cpu_rd_ack", cpu_rd_ack, m_ack);
    chk("cpu_rdata", cpu_rdata, m_crd);
  endtask

  task automatic do_reset();
    render_req = 0; cpu_wr_req = 0; cpu_rd_req = 0; grayscale = 0;
    render_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    reset_n = 0;
    #1;
    chk("rst_render_valid", render_valid, 0);
    chk("rst_render_data", render_data, 0);
    chk("rst_cpu_rd_ack", cpu_rd_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_wr_ack", cpu_wr_ack, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  typedef struct { logic [4:0] addr; logic gray; logic [4:0] maddr; logic [7:0] data; } vec_t;
  vec_t vecs[8];

  initial begin
    bit seen, last_ack;
    int w;
    for (int i = 0; i < 32; i++) begin
      pal[i]   = init_val(i);
      m_mem[i] = init_val(i);
    end
    vecs[0] = '{addr: 5'h01, gray: 0, maddr: 5'h01, data: 8'h29};
    vecs[1] = '{addr: 5'h14, gray: 0, maddr: 5'h04, data: 8'h22};
    vecs[2] = '{addr: 5'h10, gray: 0, maddr: 5'h00, data: 8'h03};
    vecs[3] = '{addr: 5'h11, gray: 0, maddr: 5'h11, data: 8'h3A};
    vecs[4] = '{addr: 5'h1C, gray: 0, maddr: 5'h0C, data: 8'h17};
    vecs[5] = '{addr: 5'h1F, gray: 0, maddr: 5'h1F, data: 8'h1C};
    vecs[6] = '{addr: 5'h02, gray: 0, maddr: 5'h02, data: 8'h1A};
`ifdef PALETTE_GRAYSCALE_EN
    vecs[7] = '{addr: 5'h02, gray: 1, maddr: 5'h02, data: 8'h10};
`else
    vecs[7] = '{addr: 5'h02, gray: 1, maddr: 5'h02, data: 8'h1A};
`endif

    @(posedge clk); #1;
    do_reset();

    // Renderer lookups, back to back.
    for (int i = 0; i < 8; i++) begin
      render_req = 1; render_addr = vecs[i].addr; grayscale = vecs[i].gray;
      settle();
      chk("vec_mem_addr", mem_addr, vecs[i].maddr);
      tick();
      chk("vec_valid", render_valid, 1);
      chk("vec_data", render_data, vecs[i].data);
    end
    render_req = 0; grayscale = 0;

    // Write 0x3F @0x05 through the FIFO, then read it back.
    cpu_wr_req = 1; cpu_addr = 5'h05; cpu_wdata = 8'h3F;
    settle(); chk("wr_ack", cpu_wr_ack, 1); tick();
    cpu_wr_req = 0;
    settle();
    chk("wr_drain_we", mem_we, 1);
    chk("wr_drain_addr", mem_addr, 8'h05);
    chk("wr_drain_data", mem_wdata, 8'h3F);
    tick();
    cpu_rd_req = 1;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      settle(); tick();
      if (cpu_rd_ack) begin seen = 1; chk("rd_data", cpu_rdata, 8'h3F); end
    end
    chk("rd_ack_seen", seen, 1);
    cpu_rd_req = 0;
    settle(); tick();
    chk("rd_ack_pulse", cpu_rd_ack, 0);

    // Same-cycle write 0x11 @0x10 and read of 0x00: write must land first.
    cpu_wr_req = 1; cpu_rd_req = 1; cpu_addr = 5'h10; cpu_wdata = 8'h11;
    settle(); chk("raw_wr_ack", cpu_wr_ack, 1); chk("raw_no_rd", mem_we, 0); tick();
    cpu_wr_req = 0; cpu_addr = 5'h00;
    settle(); chk("raw_we", mem_we, 1); chk("raw_addr", mem_addr, 8'h00); tick();
    chk("raw_no_early_ack", cpu_rd_ack, 0);
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      settle(); tick();
      if (cpu_rd_ack) begin seen = 1; chk("raw_rdata", cpu_rdata, 8'h11); end
    end
    chk("raw_ack_seen", seen, 1);
    cpu_rd_req = 0;
    settle(); tick();

    // Continuous rendering with five writes: FIFO fills, starvation forces one drain.
    do_reset();
    render_req = 1; render_addr = 5'h01; w = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      cpu_wr_req = (w < 5); cpu_addr = 5'(8 + w); cpu_wdata = 8'(8'h40 + w);
      settle();
      if (cyc == 4) begin
        chk("starve_full", fifo_full, 1);
        chk("starve_nack", cpu_wr_ack, 0);
      end
      chk("starve_we", mem_we, (cyc == 9) ? 8'd1 : 8'd0);
      if (cyc == 9) begin
        chk("starve_addr", mem_addr, 8'h08);
        chk("starve_wdata", mem_wdata, 8'h40);
      end
      tick();
      if (cyc == 9) chk("starve_render_gap", render_valid, 0);
      if (e_ack) w++;
    end
    cpu_wr_req = 0;

    // Reset with writes queued and a read pending: everything discarded, no ack.
    cpu_rd_req = 1;
    settle(); tick();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("post_rst_we", mem_we, 0);
      tick();
      chk("post_rst_ack", cpu_rd_ack, 0);
    end

    // Randomized traffic against the model.
    last_ack = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) begin do_reset(); last_ack = 0; end
      render_req  = ((cyc / 100) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      render_addr = 5'($urandom);
      grayscale   = 1'($urandom);
      if (!cpu_wr_req || last_ack) begin
        cpu_wr_req = ($urandom_range(0, 3) == 0);
        cpu_addr   = 5'($urandom);
        cpu_wdata  = 8'($urandom);
      end
      if (cpu_rd_req && m_ack)  cpu_rd_req = 0;
      else if (!cpu_rd_req)     cpu_rd_req = ($urandom_range(0, 4) == 0);
      settle();
      last_ack = e_ack;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
